button_conditioner: RTL and testbench

//  Front end for the clock/timekeeper core. Two raw pad buttons (increment, mode) are

---
 rtl/button_conditioner.sv | 198 +++++++++++++++++++
 tb/tb_button_conditioner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Two-button pad front end: per-channel 2-flop sync, debounce FSM and registered one-cycle pulses.
// Optional increment auto-repeat is built when AUTOREPEAT_EN is defined.

// Channel states:
//   state        | meaning
//   IDLE         | accepted level low, synced input low
//   PRESS_WAIT   | synced input high, counting stable-high samples
//   HELD         | accepted level high (auto-repeat timing runs here when enabled)
//   RELEASE_WAIT | synced input low while held, counting stable-low samples
module button_channel #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 8,
   parameter int REPEAT_DELAY    = 200,
   parameter int REPEAT_PERIOD   = 50,
   parameter bit REPEAT_EN       = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic pulse_req,
   output logic level
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] DEB_TC     = CNT_W'(DEBOUNCE_CYCLES);
   // Repeat timing reuses the counter: first pulse at REPEAT_DELAY, then reload so
   // the next terminal count arrives REPEAT_PERIOD later (needs PERIOD <= DELAY).
   localparam logic [CNT_W-1:0] REP_TC     = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;
   logic              level_q, level_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
      end
   end

   always_comb begin
      sync1_d   = btn_in;
      sync2_d   = sync1_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      pulse_req = 1'b0;
      cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (sync2_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         PRESS_WAIT: begin
            if (!sync2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_inc == DEB_TC) begin
               state_d   = HELD;
               cnt_d     = '0;
               pulse_req = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         HELD: begin
            if (!sync2_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CNT_W'(1);
            end else if (REPEAT_EN) begin
               if (cnt_q == REP_TC) begin
                  pulse_req = 1'b1;
                  cnt_d     = REP_RELOAD;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         RELEASE_WAIT: begin
            if (sync2_q) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_inc == DEB_TC) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
   end

   assign level = level_q;

endmodule

module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 8,
   parameter int REPEAT_DELAY    = 200,
   parameter int REPEAT_PERIOD   = 50
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_increment_in,
   input  logic btn_mode_in,
   output logic increment_pulse,
   output logic mode_pulse,
   output logic increment_level,
   output logic mode_level
);

`ifdef AUTOREPEAT_EN
   localparam bit INC_REPEAT = 1'b1;
`else
   localparam bit INC_REPEAT = 1'b0;
`endif

   logic inc_req;
   logic mode_req;
   logic inc_pulse_q, inc_pulse_d;
   logic mode_pulse_q, mode_pulse_d;

   button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (INC_REPEAT)
   ) u_inc (
      .clk       (clk),
      .reset     (reset),
      .btn_in    (btn_increment_in),
      .pulse_req (inc_req),
      .level     (increment_level)
   );

   button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (1'b0)
   ) u_mode (
      .clk       (clk),
      .reset     (reset),
      .btn_in    (btn_mode_in),
      .pulse_req (mode_req),
      .level     (mode_level)
   );

   // Mode wins a same-cycle collision; the increment pulse is dropped, not deferred.
   always_comb begin
      mode_pulse_d = mode_req;
      inc_pulse_d  = inc_req & ~mode_req;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inc_pulse_q  <= 1'b0;
         mode_pulse_q <= 1'b0;
      end else begin
         inc_pulse_q  <= inc_pulse_d;
         mode_pulse_q <= mode_pulse_d;
      end
   end

   assign increment_pulse = inc_pulse_q;
   assign mode_pulse      = mode_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a run-length debounce model predicts every
// cycle's outputs; directed scenarios also check pulse timing. Honors AUTOREPEAT_EN.
module tb_button_conditioner;

   localparam int DC = 4;
   localparam int CW = 8;
   localparam int RD = 20;
   localparam int RP = 5;
`ifdef AUTOREPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic inc_in = 1'b0;
   logic mode_in = 1'b0;
   logic increment_pulse, mode_pulse, increment_level, mode_level;

   button_conditioner #(
      .DEBOUNCE_CYCLES (DC),
      .CNT_W           (CW),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .btn_increment_in (inc_in),
      .btn_mode_in      (mode_in),
      .increment_pulse  (increment_pulse),
      .mode_pulse       (mode_pulse),
      .increment_level  (increment_level),
      .mode_level       (mode_level)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   logic [3:0] exp_q[$];
   int inc_seen[$];
   int mode_seen[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Accepted level flips after DC consecutive synced samples disagreeing with it.
   // hold counts consecutive high samples since acceptance; -1 marks a broken hold.
   task automatic chan(input bit s, input bit rep, inout bit lvl, inout int run,
                       inout int hold, output bit fire);
      fire = 1'b0;
      if (s != lvl) begin
         run++;
         if (lvl) hold = -1;
         if (run == DC) begin
            lvl = s;
            run = 0;
            if (s) begin
               fire = 1'b1;
               hold = 0;
            end
         end
      end else begin
         run = 0;
         if (lvl) begin
            hold++;
            if (rep && hold >= RD && ((hold - RD) % RP) == 0) fire = 1'b1;
         end
      end
   endtask

   initial begin : model
      bit s1i, s2i, s1m, s2m, li, lm, fi, fm;
      int ri, rm, hi, hm;
      s1i = 0; s2i = 0; s1m = 0; s2m = 0; li = 0; lm = 0;
      ri = 0; rm = 0; hi = 0; hm = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (reset) begin
            s1i = 0; s2i = 0; s1m = 0; s2m = 0; li = 0; lm = 0;
            ri = 0; rm = 0; hi = 0; hm = 0;
            fi = 0; fm = 0;
         end else begin
            chan(s2i, REP, li, ri, hi, fi);
            chan(s2m, 1'b0, lm, rm, hm, fm);
            s2i = s1i; s1i = inc_in;
            s2m = s1m; s1m = mode_in;
         end
         exp_q.push_back({fi & ~fm, fm, li, lm});
      end
   end

   initial begin : monitor
      logic [3:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("increment_pulse", int'(increment_pulse), int'(e[3]));
            check("mode_pulse", int'(mode_pulse), int'(e[2]));
            check("increment_level", int'(increment_level), int'(e[1]));
            check("mode_level", int'(mode_level), int'(e[0]));
            if (increment_pulse) inc_seen.push_back(cyc);
            if (mode_pulse) mode_seen.push_back(cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin : stim
      int e;
      int rep_exp[$];
      int left_i, left_m;

      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(50);
      check("idle_inc_pulses", inc_seen.size(), 0);
      check("idle_mode_pulses", mode_seen.size(), 0);

      // single long press
      inc_seen.delete();
      e = cyc;
      inc_in = 1'b1;
      tick(30);
      inc_in = 1'b0;
      tick(20);
      check("press_inc_count", inc_seen.size(), REP ? 2 : 1);
      if (inc_seen.size() > 0) check("press_inc_cycle", inc_seen[0], e + 6);

      // glitch train on mode
      mode_seen.delete();
      for (int k = 0; k < 5; k++) begin
         mode_in = 1'b1;
         tick(3);
         mode_in = 1'b0;
         tick(2);
      end
      tick(10);
      check("glitch_mode_count", mode_seen.size(), 0);

      // simultaneous rise
      inc_seen.delete();
      mode_seen.delete();
      e = cyc;
      inc_in = 1'b1;
      mode_in = 1'b1;
      tick(15);
      inc_in = 1'b0;
      mode_in = 1'b0;
      tick(15);
      check("simul_mode_count", mode_seen.size(), 1);
      if (mode_seen.size() > 0) check("simul_mode_cycle", mode_seen[0], e + 6);
      check("simul_inc_count", inc_seen.size(), 0);

      // reset mid-press, button held through
      inc_seen.delete();
      e = cyc;
      inc_in = 1'b1;
      tick(3);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(20);
      inc_in = 1'b0;
      tick(15);
      check("rst_press_count", inc_seen.size(), 1);
      if (inc_seen.size() > 0) check("rst_press_cycle", inc_seen[0], e + 11);

      // 50-cycle hold
      inc_seen.delete();
      rep_exp.delete();
      rep_exp.push_back(6);
      if (REP) begin
         rep_exp.push_back(26); rep_exp.push_back(31); rep_exp.push_back(36);
         rep_exp.push_back(41); rep_exp.push_back(46); rep_exp.push_back(51);
      end
      e = cyc;
      inc_in = 1'b1;
      tick(50);
      inc_in = 1'b0;
      tick(20);
      check("hold50_count", inc_seen.size(), rep_exp.size());
      for (int k = 0; k < rep_exp.size(); k++)
         if (k < inc_seen.size()) check("hold50_cycle", inc_seen[k] - e, rep_exp[k]);

      // random bouncing, occasional reset
      left_i = 0;
      left_m = 0;
      for (int k = 0; k < 3000; k++) begin
         if (left_i == 0) begin
            inc_in = 1'($urandom % 2);
            left_i = $urandom_range(1, 30);
         end
         if (left_m == 0) begin
            mode_in = 1'($urandom % 2);
            left_m = $urandom_range(1, 30);
         end
         reset = ($urandom % 500) == 0;
         left_i--;
         left_m--;
         tick(1);
      end
      reset = 1'b0;
      inc_in = 1'b0;
      mode_in = 1'b0;
      tick(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
